// File: rtl/ultrasonic_echo_if.sv
// Measurement bus between the trigger controller side and the echo timer.
// The master drives the trigger-busy flag and the raw echo pin; the slave reports results.
interface ultrasonic_echo_if #(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned DIST_W = 10
);
   logic              triging;
   logic              echo;
   logic              busy;
   logic              dist_valid;
   logic [DIST_W-1:0] dist_cm;
   logic [CNT_W-1:0]  echo_us;
   logic              timeout;

   modport master (
      output triging, echo,
      input  busy, dist_valid, dist_cm, echo_us, timeout
   );

   modport slave (
      input  triging, echo,
      output busy, dist_valid, dist_cm, echo_us, timeout
   );
endinterface

// File: rtl/ultrasonic_echo.sv
// Ultrasonic echo timer: measures echo high time after a trigger and converts it to
// centimetres with a repeated-subtraction divider, flagging missing or overlong echoes.
module ultrasonic_echo #(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned DIST_W       = 10,
   parameter int unsigned ECHO_WAIT_US = 2000,
   parameter int unsigned MAX_ECHO_US  = 30000,
   parameter int unsigned US_PER_CM    = 58
) (
   input logic               clk,
   input logic               rst,
   ultrasonic_echo_if.slave  bus
);

   localparam logic [DIST_W-1:0] DIST_MAX  = '1;
   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(ECHO_WAIT_US - 1);
   localparam logic [CNT_W-1:0]  ECHO_MAX  = CNT_W'(MAX_ECHO_US);
   localparam logic [CNT_W-1:0]  DIVISOR   = CNT_W'(US_PER_CM);
   localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RISE,
      MEASURE,
      DRAIN,
      DIVIDE,
      DONE
   } state_t;

   state_t           state;
   logic             echo_m;
   logic             echo_s;
   logic             echo_d;
   logic             triging_d;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] rem;
   logic [CNT_W-1:0] q;

   logic rise;
   logic fall;
   logic start;

   assign rise  = echo_s & ~echo_d;
   assign fall  = ~echo_s & echo_d;
   assign start = triging_d & ~bus.triging;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         echo_m         <= 1'b0;
         echo_s         <= 1'b0;
         echo_d         <= 1'b0;
         triging_d      <= 1'b0;
         wait_cnt       <= '0;
         cnt            <= '0;
         rem            <= '0;
         q              <= '0;
         bus.busy       <= 1'b0;
         bus.dist_valid <= 1'b0;
         bus.dist_cm    <= '0;
         bus.echo_us    <= '0;
         bus.timeout    <= 1'b0;
      end else begin
         echo_m         <= bus.echo;
         echo_s         <= echo_m;
         echo_d         <= echo_s;
         triging_d      <= bus.triging;
         bus.dist_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= WAIT_RISE;
                  wait_cnt <= '0;
                  bus.busy <= 1'b1;
               end
            end

            WAIT_RISE: begin
               if (rise) begin
                  state <= MEASURE;
                  cnt   <= ONE;
               end else if (wait_cnt == WAIT_LAST) begin
                  bus.echo_us    <= '0;
                  bus.dist_cm    <= DIST_MAX;
                  bus.timeout    <= 1'b1;
                  bus.dist_valid <= 1'b1;
                  state          <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + ONE;
               end
            end

            // Within MEASURE echo_d is always high, so a fall is exactly echo_s dropping.
            MEASURE: begin
               if (fall) begin
                  bus.echo_us <= cnt;
                  rem         <= cnt;
                  q           <= '0;
                  state       <= DIVIDE;
               end else if (cnt == ECHO_MAX) begin
                  bus.echo_us <= ECHO_MAX;
                  bus.dist_cm <= DIST_MAX;
                  bus.timeout <= 1'b1;
                  state       <= DRAIN;
               end else begin
                  cnt <= cnt + ONE;
               end
            end

            DRAIN: begin
               if (!echo_s) begin
                  bus.dist_valid <= 1'b1;
                  state          <= DONE;
               end
            end

            DIVIDE: begin
               if (rem >= DIVISOR) begin
                  rem <= rem - DIVISOR;
                  q   <= q + ONE;
               end else begin
                  bus.dist_cm    <= (q > CNT_W'(DIST_MAX)) ? DIST_MAX : DIST_W'(q);
                  bus.timeout    <= 1'b0;
                  bus.dist_valid <= 1'b1;
                  state          <= DONE;
               end
            end

            DONE: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ultrasonic_echo.md
Name: ultrasonic_echo

Overview:
Downstream stage of the ultrasonic trigger generator. After each trigger pulse it measures the sensor echo pulse width in 1 us clock cycles and converts it to centimetres with a sequential divider. It flags timeouts, and reports busy so the controller can space its trigger requests. It runs on the same 1 us clock as the trigger stage and feeds the distance register and obstacle logic.

Parameters:
CNT_W, 16, width of the echo and wait counters; must hold MAX_ECHO_US.
DIST_W, 10, width of dist_cm; saturates at 2^DIST_W-1.
ECHO_WAIT_US, 2000, maximum cycles allowed from the end of the trigger to the echo rising edge.
MAX_ECHO_US, 30000, maximum echo high time counted; beyond this the result is out of range.
US_PER_CM, 58, divisor converting echo microseconds to centimetres.

Ports:
clk  in  1  1 us measurement clock, shared with the trigger stage.
rst  in  1  asynchronous, active-high reset.
triging  in  1  busy flag from the trigger stage; its falling edge starts a measurement.
echo  in  1  raw sensor echo pin; asynchronous to clk.
busy  out  1  high from the measurement start until the cycle after dist_valid.
dist_valid  out  1  one-cycle pulse when a new result is posted.
dist_cm  out  DIST_W  distance in cm, floor division, saturated; held until the next result.
echo_us  out  CNT_W  measured echo high time in cycles; held until the next result.
timeout  out  1  set with each result if that measurement timed out; held until the next result.

Behaviour:
Reset and input conditioning:
- Reset is asynchronous and active-high. Under reset: state=IDLE; busy, dist_valid, timeout = 0; dist_cm, echo_us = 0; all counters and synchronizers cleared.
- echo passes through a 2-flop synchronizer to give echo_s, then a registered copy echo_d.
- rise = echo_s & ~echo_d; fall = ~echo_s & echo_d. Pin-to-detection latency is 2 cycles; width is unaffected.
- triging is registered to triging_d; start = triging_d & ~triging.

State machine:
- IDLE: on start, go to WAIT_RISE, wait_cnt=0, busy=1. With no start, stay in IDLE.
- WAIT_RISE:
  - If rise: go to MEASURE with cnt=1.
  - Else if wait_cnt==ECHO_WAIT_US-1: timeout. Set echo_us=0, dist_cm=all ones, timeout=1, go to DONE.
  - Otherwise wait_cnt++.
- MEASURE:
  - While echo_s=1: cnt++.
  - On echo_s=0: echo_us=cnt, go to DIVIDE.
  - If echo_s=1 and cnt==MAX_ECHO_US: echo_us=MAX_ECHO_US, dist_cm=all ones, timeout=1, go to DRAIN.
- DRAIN: stay until echo_s=0, then go to DONE. A stuck-high echo therefore holds busy=1 indefinitely.
- DIVIDE: rem=echo_us and q=0 on entry. Each cycle:
  - If rem>=US_PER_CM: rem-=US_PER_CM, q++.
  - Else: dist_cm=min(q, 2^DIST_W-1), timeout=0, go to DONE.
  - Takes floor(echo_us/US_PER_CM)+1 cycles.
- DONE: dist_valid=1 for exactly this cycle, then go to IDLE with busy=0.

Timing and boundaries:
- Result latency after echo_s falls: dist_valid rises floor(echo_us/58)+2 cycles later. For MAX_ECHO_US this is ≤519 cycles.
- start while busy=1 is ignored; there is no queueing.
- A rise seen in IDLE (echo with no trigger) is ignored.
- echo_us=US_PER_CM-1 gives dist_cm=0 and timeout=0.
- Counters never wrap: CNT_W bits must satisfy 2^CNT_W > MAX_ECHO_US and > ECHO_WAIT_US.
- Asserting rst mid-measurement aborts immediately to reset values. No dist_valid is produced for the aborted measurement.

Test Plan:
- Clean echo: triging 1→0, echo high 580 cycles after 400 cycles → dist_valid once, echo_us=580, dist_cm=10, timeout=0; busy falls the cycle after dist_valid; dist_valid within 12 cycles of echo_s falling.
- Short echo: echo high 57 cycles → echo_us=57, dist_cm=0; 1-cycle echo → echo_us=1, dist_cm=0.
- No echo: triging falls, echo stays 0 → after 2000 cycles dist_valid with timeout=1, echo_us=0, dist_cm=1023.
- Long echo: echo held high 40000 cycles → no dist_valid until echo falls; then dist_valid with timeout=1, echo_us=30000, dist_cm=1023.
- Retrigger and stray echo:
  - second triging falling edge during MEASURE is ignored; the result is for the first echo only.
  - echo pulse in IDLE gives no dist_valid.
  - outputs hold between results.
- Reset mid-MEASURE: assert rst at cnt=300 → all outputs 0 asynchronously; after release a new full cycle of 1160 cycles gives dist_cm=20.
